// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and constants for fifo_synchronous and its read-side stream adapter
//   DEF_SIZE_DATA : default data width shared by the FIFO and the adapter
//   occ_t         : occupancy of the 2-entry output buffer (EMPTY/ONE/TWO)
//   beat_w()      : width of a beat counter for a given packet length (at least 1 bit)
package fifo_pkg;
   localparam int DEF_SIZE_DATA = 8;
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;
   function automatic int beat_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/skid_buf2.sv
// skid_buf2: 2-entry in-order buffer with registered head; push and pop may coincide
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write i_data at the tail
//   i_pop          : drop the head entry
//   o_data         : head entry (registered)
//   o_occ          : current occupancy
module skid_buf2 import fifo_pkg::*; #(
   parameter int SIZE_DATA = DEF_SIZE_DATA
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_push,
   input  logic                 i_pop,
   input  logic [SIZE_DATA-1:0] i_data,
   output logic [SIZE_DATA-1:0] o_data,
   output occ_t                 o_occ
);
   logic [SIZE_DATA-1:0] r_head, r_tail;
   occ_t                 r_occ, w_occ_next;
   always_comb w_occ_next = occ_t'(r_occ + {1'b0, i_push} - {1'b0, i_pop});
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_occ  <= EMPTY;
         r_head <= '0;
         r_tail <= '0;
      end else begin
         r_occ <= w_occ_next;
         // Head takes the second entry when full, else the incoming word when it lands at the front
         if (i_pop && r_occ == TWO)
            r_head <= r_tail;
         else if (i_push && (r_occ == EMPTY || (r_occ == ONE && i_pop)))
            r_head <= i_data;
         if (i_push && w_occ_next == TWO)
            r_tail <= i_data;
      end
   end
   assign o_data = r_head;
   assign o_occ  = r_occ;
   a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(i_push && !i_pop && r_occ == TWO));
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains fifo_synchronous into a valid/ready stream framed into PKT_LEN-beat packets
//   i_clk, i_rst_n   : clock, asynchronous active-low reset (shared with the FIFO)
//   i_fifo_empty     : FIFO o_empty
//   i_fifo_data      : FIFO o_data, valid the cycle after a read
//   o_fifo_rd_en     : FIFO i_rd_en
//   o_valid, i_ready : stream handshake
//   o_data, o_last   : stream beat and end-of-packet marker
//   o_busy           : buffer holds data or a read is in flight
//   FIFO_RD_STREAM_STATS_EN adds o_beat_cnt (32b, beats accepted) and o_pkt_cnt (16b, packets accepted)
module fifo_rd_stream import fifo_pkg::*; #(
   parameter int SIZE_DATA = DEF_SIZE_DATA,
   parameter int PKT_LEN   = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_fifo_empty,
   input  logic [SIZE_DATA-1:0] i_fifo_data,
   output logic                 o_fifo_rd_en,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [SIZE_DATA-1:0] o_data,
   output logic                 o_last,
   output logic                 o_busy
`ifdef FIFO_RD_STREAM_STATS_EN
   ,
   output logic [31:0]          o_beat_cnt,
   output logic [15:0]          o_pkt_cnt
`endif
);
   localparam int          BW        = beat_w(PKT_LEN);
   localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);
   logic          r_inflight;
   logic [BW-1:0] r_beat;
   occ_t          w_occ;
   logic          w_pop;
   logic [2:0]    w_level;
   // Credit: issue a read only if the word still fits once this cycle's pop is taken into account
   always_comb begin
      w_pop        = o_valid & i_ready;
      w_level      = {1'b0, w_occ} + {2'b00, r_inflight};
      o_fifo_rd_en = !i_fifo_empty && (w_level < 3'd2 + {2'b00, w_pop});
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_inflight <= 1'b0;
         r_beat     <= '0;
      end else begin
         r_inflight <= o_fifo_rd_en;
         if (w_pop)
            r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
      end
   end
   skid_buf2 #(.SIZE_DATA(SIZE_DATA)) u_buf (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (r_inflight),
      .i_pop   (w_pop),
      .i_data  (i_fifo_data),
      .o_data  (o_data),
      .o_occ   (w_occ)
   );
   assign o_valid = (w_occ != EMPTY);
   assign o_last  = o_valid && (r_beat == LAST_BEAT);
   assign o_busy  = o_valid | r_inflight;
`ifdef FIFO_RD_STREAM_STATS_EN
   logic [31:0] r_beat_cnt;
   logic [15:0] r_pkt_cnt;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_beat_cnt <= '0;
         r_pkt_cnt  <= '0;
      end else if (w_pop) begin
         r_beat_cnt <= r_beat_cnt + 32'd1;
         if (o_last)
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
   end
   assign o_beat_cnt = r_beat_cnt;
   assign o_pkt_cnt  = r_pkt_cnt;
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: bench for fifo_rd_stream with a behavioural FIFO and a word/count reference model
module tb_fifo_rd_stream;
   localparam int PL = 4;
   logic       clk = 1'b0;
   logic       rst_n, fifo_empty, ready;
   logic [7:0] fifo_data;
   logic       rd_en, valid, last, busy, rd_en1, valid1, last1, busy1;
   logic [7:0] data, data1;
`ifdef FIFO_RD_STREAM_STATS_EN
   logic [31:0] bc, bc1;
   logic [15:0] pc, pc1;
`endif
   always #5 clk = ~clk;

   fifo_rd_stream #(.SIZE_DATA(8), .PKT_LEN(PL)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data),
      .o_fifo_rd_en(rd_en), .o_valid(valid), .i_ready(ready), .o_data(data), .o_last(last), .o_busy(busy)
`ifdef FIFO_RD_STREAM_STATS_EN
      , .o_beat_cnt(bc), .o_pkt_cnt(pc)
`endif
   );
   fifo_rd_stream #(.SIZE_DATA(8), .PKT_LEN(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data),
      .o_fifo_rd_en(rd_en1), .o_valid(valid1), .i_ready(ready), .o_data(data1), .o_last(last1), .o_busy(busy1)
`ifdef FIFO_RD_STREAM_STATS_EN
      , .o_beat_cnt(bc1), .o_pkt_cnt(pc1)
`endif
   );

   logic [7:0] q[$];
   logic [7:0] exp_q[$];
   int checks = 0, errors = 0;
   int n_rd, n_arr, n_pop, n_last;
   logic ps, rs, ev, prev_stall;
   logic [7:0] prev_data;

   typedef struct {
      logic       rdy;
      logic       rd;
      logic       v;
      logic [7:0] d;
      logic       l;
      logic       b;
   } vec_t;
   vec_t tv[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic wr(input logic [7:0] d);
      q.push_back(d);
      exp_q.push_back(d);
      fifo_empty = 1'b0;
   endtask

   // Runs from the falling edge up to just before the rising edge
   task automatic pre(input logic rdy);
      logic [7:0] e;
      ready = rdy;
      #4;
      ev = n_arr > n_pop;
      ps = ev & rdy;
      chk("valid", valid, ev);
      chk("valid1", valid1, ev);
      chk("busy", busy, n_rd > n_pop);
      chk("busy1", busy1, n_rd > n_pop);
      chk("rd_en", rd_en, !fifo_empty && (n_rd - n_pop - int'(ps) < 2));
      chk("rd_en1", rd_en1, !fifo_empty && (n_rd - n_pop - int'(ps) < 2));
      chk("last", last, ev && (n_pop % PL == PL - 1));
      chk("last1", last1, ev);
      if (prev_stall) chk("stall_data", data, prev_data);
      if (ps) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_beat: got %0h expected no beat", data);
         end else begin
            e = exp_q.pop_front();
            chk("data", data, e);
            chk("data1", data1, e);
         end
         if (last) n_last++;
      end
      prev_stall = ev & !rdy;
      prev_data  = data;
      rs = rd_en & !fifo_empty;
   endtask

   task automatic post();
      @(posedge clk);
      #1;
      n_arr = n_rd;
      n_rd += int'(rs);
      n_pop += int'(ps);
      if (rs) fifo_data = q.pop_front();
      fifo_empty = (q.size() == 0);
      @(negedge clk);
   endtask

   task automatic step(input logic rdy);
      pre(rdy);
      post();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      q.delete();
      exp_q.delete();
      fifo_empty = 1'b1;
      fifo_data = '0;
      ready = 1'b0;
      n_rd = 0; n_arr = 0; n_pop = 0; n_last = 0;
      prev_stall = 1'b0;
      #1;
      chk("rst_rd_en", rd_en, 0);
      chk("rst_valid", valid, 0);
      chk("rst_data", data, 0);
      chk("rst_last", last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid1", valid1, 0);
      chk("rst_busy1", busy1, 0);
`ifdef FIFO_RD_STREAM_STATS_EN
      chk("rst_beat_cnt", bc, 0);
      chk("rst_pkt_cnt", pc, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain(input int mode);
      int k = 0;
      while (exp_q.size() != 0 && k < 300) begin
         step(mode == 0 ? 1'b1 : mode == 1 ? 1'((k % 4 == 0) || (k % 4 == 3)) : 1'($urandom_range(0, 1)));
         k++;
      end
      chk("drain_left", exp_q.size(), 0);
      repeat (3) step(1'b1);
   endtask

   initial begin
      tv[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      tv[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
      tv[2] = '{1'b1, 1'b1, 1'b1, 8'h29, 1'b0, 1'b1};
      tv[3] = '{1'b1, 1'b1, 1'b1, 8'h30, 1'b0, 1'b1};
      tv[4] = '{1'b1, 1'b0, 1'b1, 8'h31, 1'b0, 1'b1};
      tv[5] = '{1'b1, 1'b0, 1'b1, 8'h32, 1'b1, 1'b1};
      tv[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      rst_n = 1'b0;
      ready = 1'b0;
      fifo_empty = 1'b1;
      fifo_data = '0;
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 10; i++) begin
         pre(1'b1);
         chk("idle_data", data, 0);
         post();
      end
      wr(8'h29); wr(8'h30); wr(8'h31); wr(8'h32);
      for (int i = 0; i < 7; i++) begin
         pre(tv[i].rdy);
         chk("tv_rd_en", rd_en, tv[i].rd);
         chk("tv_valid", valid, tv[i].v);
         if (tv[i].v) chk("tv_data", data, tv[i].d);
         chk("tv_last", last, tv[i].l);
         chk("tv_busy", busy, tv[i].b);
         post();
      end
      for (int i = 0; i < 4; i++) wr(8'h50 + 8'(i));
      repeat (3) step(1'b0);
      chk("two_busy", busy, 1);
      do_reset();
      for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i));
      drain(1);
      do_reset();
      for (int i = 0; i < 6; i++) wr(8'h60 + 8'(i));
      drain(2);
      chk("lasts_after6", n_last, 1);
      repeat (4) step(1'b1);
      wr(8'h66); wr(8'h67);
      drain(0);
      chk("lasts_after8", n_last, 2);
      do_reset();
      for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i));
      drain(0);
      chk("lasts_16", n_last, 4);
`ifdef FIFO_RD_STREAM_STATS_EN
      chk("beat_cnt", bc, 16);
      chk("pkt_cnt", pc, 4);
      chk("pkt_cnt1", pc1, 16);
`endif
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (q.size() < 16 && $urandom_range(0, 2) != 0) wr(8'($urandom));
         step(1'($urandom_range(0, 3) != 0));
      end
      drain(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter between `fifo_synchronous` and any valid/ready consumer. It drains the FIFO through its `i_rd_en`/`o_empty` pins and absorbs the FIFO's one-cycle read latency in a 2-entry output buffer. It presents data as a valid/ready stream at one beat per clock with no bubbles. It also frames the stream into fixed-length packets with a `o_last` marker.

## Interface
- `SIZE_DATA`, 8: data width; must equal the FIFO's `SIZE_DATA`.
- `PKT_LEN`, 4: beats per packet, ≥1; beat counter width `max(1,$clog2(PKT_LEN))`.
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- `i_clk`  in  1  single clock, rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_fifo_empty`  in  1  FIFO `o_empty`.
- `i_fifo_data`  in  SIZE_DATA  FIFO `o_data`.
- `o_fifo_rd_en`  out  1  drives FIFO `i_rd_en`.
- `o_valid`  out  1  output beat available.
- `i_ready`  in  1  consumer accepts beat.
- `o_data`  out  SIZE_DATA  output beat.
- `o_last`  out  1  current beat is the final beat of its packet.
- `o_busy`  out  1  buffer non-empty or read in flight.

## Operation
- FIFO contract: a read issued in cycle N (`i_rd_en`=1, not empty) shows its word on `i_fifo_data` in cycle N+1.
- State:
  - `inflight` (1 bit): registered copy of `o_fifo_rd_en`.
  - `occ` ∈ {EMPTY=0, ONE=1, TWO=2}: 2-entry buffer occupancy.
  - beat counter `beat`.
- `pop = o_valid & i_ready`.
- `o_fifo_rd_en = !i_fifo_empty & (occ + inflight - pop < 2)`.
  - This is combinational from `i_ready`; it is the only comb path.
- When `inflight`=1, `i_fifo_data` is written to the buffer tail.
- Transitions: `occ_next = occ + inflight - pop`.
  - Credit rule guarantees `occ_next` ≤ 2.
  - Overflow is impossible by construction; check it with an assertion.
- `o_valid = (occ != EMPTY)`. `o_data` = buffer head, registered storage.
- `o_data` holds stable while `o_valid & !i_ready`.
- `o_last = (beat == PKT_LEN-1)`, qualified by `o_valid`.
  - `beat` increments on `pop` and wraps to 0 after `PKT_LEN-1`.
  - With `PKT_LEN`=1, `o_last`=`o_valid`.
- `o_busy = (occ != EMPTY) | inflight`.
- Simultaneous push and pop:
  - At ONE: stays ONE, head replaced.
  - At TWO: stays TWO, second entry shifts to head.
- FIFO goes empty mid-packet: `o_valid` drops and `beat` is held. The packet resumes when data returns, so there is no premature `o_last`.

## Timing
- Reset values: `o_fifo_rd_en`=0, `o_valid`=0, `o_data`=0, `o_last`=0, `o_busy`=0; `occ`=EMPTY, `inflight`=0, `beat`=0.
- Reset mid-operation clears everything immediately. The buffered and in-flight words are discarded. The FIFO shares `i_rst_n` and is cleared together.
- Latency: `i_fifo_empty` falls in cycle N → `o_fifo_rd_en`=1 in N → `o_valid`=1 in N+2.
- Throughput: with `i_ready` held high and the FIFO non-empty, one beat per cycle with no gaps.
- Backpressure: `i_ready`=0 stops reads once `occ + inflight` = 2. No word is lost, and at most one read is in flight when the buffer fills.

## Configuration
- `FIFO_RD_STREAM_STATS_EN` defined adds these outputs:
  - `o_beat_cnt` (32 bit): increments on every `pop`, wraps at 2^32.
  - `o_pkt_cnt` (16 bit): increments on every `pop & o_last`, wraps at 2^16.
  - Both counters reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `fifo_pkg`:
  - `occ_t` enum (EMPTY/ONE/TWO).
  - Helper function for the beat counter width.
  - `SIZE_DATA` default constant, shared with `fifo_synchronous`.
- One sub-module, `skid_buf2`: the 2-entry buffer with push/pop/occupancy. The top level holds the credit logic, `inflight`, the packet counter and the stats counters.

## Test plan
- Reset, then idle with FIFO empty → all outputs 0 for 10 cycles; assert reset mid-stream with `occ`=TWO → outputs 0 in the same cycle.
- Write 0x29,0x30,0x31,0x32 into the FIFO, `i_ready`=1 → `o_valid` 2 cycles after empty falls; data in order, one per cycle; `o_last` only on 0x32.
- FIFO full (16 words), `i_ready` toggles 1,0,0,1 repeatedly → all 16 words delivered in order, no duplicates; `o_data` stable while stalled; `o_fifo_rd_en` never asserts when `occ + inflight - pop` would exceed 1.
- 6 words with `PKT_LEN`=4 → `o_last` on beat 4; beats 5 and 6 not last; writing 2 more words later gives `o_last` on beat 8.
- `PKT_LEN`=1 with 3 words → `o_last`=1 on every beat.
- `FIFO_RD_STREAM_STATS_EN` defined, 16 words, `PKT_LEN`=4 → `o_beat_cnt`=16, `o_pkt_cnt`=4.
